// File: rtl/vga_frame_scanout.sv
`default_nettype none
// ============================================================================
// Module      : vga_frame_scanout
// Description : Receives pixel plots into a 160x120x12-bit frame buffer and
//               continuously scans it out as VGA. Each stored pixel is shown
//               as a 4x4 block of display pixels.
// Ports       : clock, reset (async, active high)
//               VGA_X[7:0], VGA_Y[6:0], VGA_COLOR[11:0], plot : write port
//               VGA_HS, VGA_VS (active low), VGA_BLANK_N     : sync / blank
//               VGA_R, VGA_G, VGA_B [3:0]                     : colour
//               frame_start : one-clock pulse when the first pixel of a
//                             frame reaches the outputs
// Revision    : 1.0 - initial release
// ============================================================================
module vga_frame_scanout #(
    parameter int CLOCKS_PER_PIXEL = 2,
    parameter int H_VISIBLE        = 640,
    parameter int H_FRONT          = 16,
    parameter int H_SYNC           = 96,
    parameter int H_BACK           = 48,
    parameter int V_VISIBLE        = 480,
    parameter int V_FRONT          = 10,
    parameter int V_SYNC           = 2,
    parameter int V_BACK           = 33
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [7:0]  VGA_X,
    input  logic [6:0]  VGA_Y,
    input  logic [11:0] VGA_COLOR,
    input  logic        plot,
    output logic        VGA_HS,
    output logic        VGA_VS,
    output logic        VGA_BLANK_N,
    output logic [3:0]  VGA_R,
    output logic [3:0]  VGA_G,
    output logic [3:0]  VGA_B,
    output logic        frame_start
);

    localparam int H_TOTAL  = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
    localparam int V_TOTAL  = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;
    localparam int HS_START = H_VISIBLE + H_FRONT;
    localparam int HS_END   = HS_START + H_SYNC;
    localparam int VS_START = V_VISIBLE + V_FRONT;
    localparam int VS_END   = VS_START + V_SYNC;
    localparam int FB_W     = 160;
    localparam int FB_H     = 120;
    localparam int FB_DEPTH = FB_W * FB_H;
    localparam int AW       = $clog2(FB_DEPTH);
    localparam int TW       = (CLOCKS_PER_PIXEL > 2) ? $clog2(CLOCKS_PER_PIXEL) : 1;
    localparam int HW       = $clog2(H_TOTAL);
    localparam int VW       = $clog2(V_TOTAL);

    localparam logic [TW-1:0] TICK_LAST = TW'(CLOCKS_PER_PIXEL - 1);
    localparam logic [TW-1:0] TICK_PRE  = TW'(CLOCKS_PER_PIXEL - 2);
    localparam logic [HW-1:0] H_LAST    = HW'(H_TOTAL - 1);
    localparam logic [VW-1:0] V_LAST    = VW'(V_TOTAL - 1);

    // Timing counters
    logic [TW-1:0] tick_cnt_q, tick_cnt_d;
    logic [HW-1:0] h_cnt_q, h_cnt_d;
    logic [VW-1:0] v_cnt_q, v_cnt_d;
    logic          tick;

    // Decode of the current (h,v)
    logic          active;
    logic          in_hsync;
    logic          in_vsync;
    logic          first_px;
    logic [AW-1:0] rd_addr_d;

    // Stage 1: read address plus decode copies (sync held as active-high
    // "in pulse" flags so that the all-zero reset state is idle)
    logic [AW-1:0] rd_addr_q;
    logic          s1_active_q;
    logic          s1_hsync_q;
    logic          s1_vsync_q;
    logic          s1_first_q;

    // Stage 2: output registers
    logic          blank_n_q;
    logic          hs_n_q;
    logic          vs_n_q;
    logic [11:0]   rgb_q;
    logic          frame_start_q;

    // Frame buffer
    logic [11:0]   mem_q [FB_DEPTH];
    logic [11:0]   rd_data_q;
    logic          wr_en;
    logic [AW-1:0] wr_addr;

    always_comb begin
        tick       = (tick_cnt_q == TICK_LAST);
        tick_cnt_d = tick ? '0 : tick_cnt_q + 1'b1;
        h_cnt_d    = h_cnt_q;
        v_cnt_d    = v_cnt_q;
        if (tick) begin
            if (h_cnt_q == H_LAST) begin
                h_cnt_d = '0;
                v_cnt_d = (v_cnt_q == V_LAST) ? '0 : v_cnt_q + 1'b1;
            end else begin
                h_cnt_d = h_cnt_q + 1'b1;
            end
        end
    end

    always_comb begin
        active    = (32'(h_cnt_q) < H_VISIBLE) && (32'(v_cnt_q) < V_VISIBLE);
        in_hsync  = (32'(h_cnt_q) >= HS_START) && (32'(h_cnt_q) < HS_END);
        in_vsync  = (32'(v_cnt_q) >= VS_START) && (32'(v_cnt_q) < VS_END);
        first_px  = (h_cnt_q == '0) && (v_cnt_q == '0);
        rd_addr_d = '0;
        // Blanked positions read address 0 so the RAM index never leaves range
        if (active) begin
            rd_addr_d = AW'((32'(v_cnt_q) >> 2) * FB_W + (32'(h_cnt_q) >> 2));
        end
    end

    always_comb begin
        wr_en   = plot && (VGA_X < 8'(FB_W)) && (VGA_Y < 7'(FB_H));
        wr_addr = AW'(32'(VGA_Y) * FB_W + 32'(VGA_X));
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            tick_cnt_q    <= '0;
            h_cnt_q       <= '0;
            v_cnt_q       <= '0;
            rd_addr_q     <= '0;
            s1_active_q   <= 1'b0;
            s1_hsync_q    <= 1'b0;
            s1_vsync_q    <= 1'b0;
            s1_first_q    <= 1'b0;
            blank_n_q     <= 1'b0;
            hs_n_q        <= 1'b1;
            vs_n_q        <= 1'b1;
            rgb_q         <= '0;
            frame_start_q <= 1'b0;
        end else begin
            tick_cnt_q    <= tick_cnt_d;
            h_cnt_q       <= h_cnt_d;
            v_cnt_q       <= v_cnt_d;
            // Raised one clock ahead so the pulse sits on the very tick cycle
            // whose edge presents the first pixel (needs CLOCKS_PER_PIXEL>=2)
            frame_start_q <= (tick_cnt_q == TICK_PRE) && s1_first_q;
            if (tick) begin
                rd_addr_q   <= rd_addr_d;
                s1_active_q <= active;
                s1_hsync_q  <= in_hsync;
                s1_vsync_q  <= in_vsync;
                s1_first_q  <= first_px;
                blank_n_q   <= s1_active_q;
                hs_n_q      <= ~s1_hsync_q;
                vs_n_q      <= ~s1_vsync_q;
                rgb_q       <= s1_active_q ? rd_data_q : 12'h000;
            end
        end
    end

    // Synchronous RAM, read-before-write on a same-address collision
    always_ff @(posedge clock) begin
        if (wr_en) begin
            mem_q[wr_addr] <= VGA_COLOR;
        end
        rd_data_q <= mem_q[rd_addr_q];
    end

    assign VGA_BLANK_N = blank_n_q;
    assign VGA_HS      = hs_n_q;
    assign VGA_VS      = vs_n_q;
    assign VGA_R       = rgb_q[11:8];
    assign VGA_G       = rgb_q[7:4];
    assign VGA_B       = rgb_q[3:0];
    assign frame_start = frame_start_q;

endmodule
`default_nettype wire

// File: doc/vga_frame_scanout.md
Name: vga_frame_scanout

Overview:
- Receiving end of the pixel-plot interface (VGA_X / VGA_Y / VGA_COLOR plus a plot strobe) that the game-state FSM and its drawing submodules drive.
- Stores plotted pixels in an internal 160x120x12-bit frame buffer.
- Continuously scans the buffer out as 640x480 VGA: each stored pixel is replicated to a 4x4 block, with standard sync timing.
- Sits between fsm_game_state and the board's VGA DAC pins.

Parameters:
- CLOCKS_PER_PIXEL, 2, clock cycles per VGA pixel tick; must be >=2 (50 MHz clock gives a 25 MHz pixel rate).
- H_VISIBLE, 640, visible pixels per line.
- H_FRONT, 16, horizontal front porch in ticks.
- H_SYNC, 96, HS pulse width in ticks.
- H_BACK, 48, horizontal back porch in ticks.
- V_VISIBLE, 480, visible lines.
- V_FRONT, 10, vertical front porch in lines.
- V_SYNC, 2, VS pulse width in lines.
- V_BACK, 33, vertical back porch in lines.

Ports:
- clock  in  1  system clock, all logic on posedge.
- reset  in  1  asynchronous, active-high reset.
- VGA_X  in  8  plot column, 0..159.
- VGA_Y  in  7  plot row, 0..119.
- VGA_COLOR  in  12  plot colour {R[3:0],G[3:0],B[3:0]}.
- plot  in  1  write strobe, one write per cycle it is high.
- VGA_HS  out  1  horizontal sync, active low.
- VGA_VS  out  1  vertical sync, active low.
- VGA_BLANK_N  out  1  high during visible region.
- VGA_R  out  4  red.
- VGA_G  out  4  green.
- VGA_B  out  4  blue.
- frame_start  out  1  one-clock pulse at start of each frame.

Behaviour:
- **Reset (async, high).**
  - tick_cnt, h_cnt, v_cnt and all pipeline registers go to 0.
  - VGA_HS=1, VGA_VS=1, VGA_BLANK_N=0, VGA_R/G/B=0, frame_start=0.
  - Frame buffer contents are not cleared; they are undefined after power-up.
  - Reset asserted mid-line or mid-frame restarts timing at h=0, v=0 on release.
- **Pixel tick.**
  - tick_cnt counts 0..CLOCKS_PER_PIXEL-1 and wraps.
  - tick is high in the cycle where tick_cnt==CLOCKS_PER_PIXEL-1.
  - All counter and output updates occur only on tick cycles.
- **Counters.**
  - h_cnt runs 0..H_TOTAL-1, where H_TOTAL = sum of the H parameters (800).
  - On wrap, h_cnt goes to 0 and v_cnt increments.
  - v_cnt runs 0..V_TOTAL-1 (525) and wraps to 0.
- **Decode for a given (h,v).**
  - active = h<H_VISIBLE && v<V_VISIBLE.
  - hs_n is low iff H_VISIBLE+H_FRONT <= h < H_VISIBLE+H_FRONT+H_SYNC.
  - vs_n is low iff V_VISIBLE+V_FRONT <= v < V_VISIBLE+V_FRONT+V_SYNC.
- **Write port.**
  - On any cycle with plot=1, VGA_X<160 and VGA_Y<120: mem[VGA_Y*160+VGA_X] <= VGA_COLOR.
  - Out-of-range coordinates are ignored; no aliasing into another row.
  - Writes are independent of tick and never stall.
- **Read pipeline (synchronous RAM, 1-cycle read latency).**
  - Stage 1, on tick: rd_addr <= (v>>2)*160 + (h>>2). Register active, hs_n, vs_n alongside.
  - Stage 2, on next tick:
    - VGA_R/G/B <= stage-1 active ? rd_data fields : 0.
    - VGA_BLANK_N, VGA_HS, VGA_VS <= their stage-1 copies.
  - Net effect: outputs show the decode of the (h,v) from 2 ticks earlier. Colour and sync stay mutually aligned.
- **Write/read collision.** A write and a read to the same address in the same cycle returns old data. The new value appears from the next read onward.
- **frame_start.**
  - Pulses high for exactly one clock, on the tick cycle where stage 2 updates with the first pixel of the frame (h=0, v=0).
  - Its period is H_TOTAL*V_TOTAL*CLOCKS_PER_PIXEL clocks.

Test Plan:
1. Reset for 3 cycles, then release.
   - Outputs hold their reset values until the first stage-2 update.
   - First frame_start appears at clock 2*CLOCKS_PER_PIXEL-1 after release; later ones every 840000 clocks.
2. Free-run 2 lines with CLOCKS_PER_PIXEL=2.
   - VGA_HS goes low for exactly 192 clocks per line; lines are 1600 clocks.
   - HS falls 1312 clocks after BLANK_N rises, since BLANK_N is high for 1280 clocks.
3. Free-run a full frame.
   - VGA_VS goes low for exactly 2 lines (3200 clocks).
   - BLANK_N is high on 480 lines only.
4. Plot (5,3,12'hF0A), then observe the next frame.
   - R=F, G=0, B=A for h=20..23 on lines v=12..15.
   - Neighbouring h=24 shows whatever is stored at (6,3).
5. Preload (0,4)=12'h123, then plot (160,3,12'hFFF) and (7,120,12'hFFF).
   - (0,4) still reads 12'h123.
   - Nothing else changes.
6. Assert reset mid-frame at v=200.
   - All outputs return to reset values immediately (asynchronously).
   - Timing restarts at h=0, v=0; previously plotted pixels are still displayed.
